// File: rtl/interrupt_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encoding, default sizes
// and the fixed source numbering used by the game hardware.
package interrupt_scheduler_pkg;

    localparam int DEF_N_SRC   = 4;
    localparam int DEF_INSTR_W = 32;

    localparam int SRC_JUMP    = 0;
    localparam int SRC_FRAME   = 1;
    localparam int SRC_COLLIDE = 2;
    localparam int SRC_AUDIO   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/interrupt_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search begins one past the last granted
// index and wraps, so the most recently served source has the lowest priority.
module interrupt_scheduler_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_SRC-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_pos = IDX_W'((int'(i_last) + k) % N_SRC);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/interrupt_scheduler.sv
// Captures request edges, picks one enabled pending source round-robin and
// presents its vector-table instruction to the CPU until acknowledged.
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter int  N_SRC   = DEF_N_SRC,
    parameter int  INSTR_W = DEF_INSTR_W,
    localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_SRC-1:0]   i_req,
    input  logic [N_SRC-1:0]   i_mask,
    input  logic               i_cfg_we,
    input  logic [IDX_W-1:0]   i_cfg_idx,
    input  logic [INSTR_W-1:0] i_cfg_instr,
    input  logic               i_irq_ack,
    output logic [INSTR_W-1:0] o_interrupt_instruction,
    output logic               o_irq_valid,
    output logic [N_SRC-1:0]   o_pending,
    output logic [N_SRC-1:0]   o_dropped
);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic [N_SRC-1:0]   r_req_prev;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_dropped;
    logic [INSTR_W-1:0] r_table [N_SRC];
    logic [INSTR_W-1:0] r_instr;
    logic [IDX_W-1:0]   r_winner;
    logic [N_SRC-1:0]   r_winner_oh;
    logic [IDX_W-1:0]   r_last_grant;

    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_clear;
    logic [N_SRC-1:0]   w_grant_oh;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_issue_start;
    logic               w_take_ack;

    interrupt_scheduler_rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (r_pending & i_mask),
        .i_last  (r_last_grant),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_valid (w_any)
    );

    always_comb begin
        w_state_next  = r_state;
        w_issue_start = 1'b0;
        w_take_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next  = ST_ISSUE;
                    w_issue_start = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (i_irq_ack) begin
                    w_state_next = ST_GAP;
                    w_take_ack   = 1'b1;
                end
            end
            ST_GAP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_edge  = i_req & ~r_req_prev;
    assign w_clear = r_winner_oh & {N_SRC{w_take_ack}};

    // A new edge on the source being acknowledged re-arms it rather than
    // counting as a drop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_req_prev <= '0;
            r_pending  <= '0;
            r_dropped  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req_prev <= i_req;
            r_pending  <= (r_pending & ~w_clear) | w_edge;
            r_dropped  <= r_dropped | (w_edge & r_pending & ~w_clear);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_SRC; k++) begin
                r_table[k] <= '0;
            end
        end else if (i_cfg_we) begin
            r_table[i_cfg_idx] <= i_cfg_instr;
        end
    end

    // The instruction is latched at selection, so table writes during ISSUE
    // cannot disturb what the CPU sees.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr      <= '0;
            r_winner     <= '0;
            r_winner_oh  <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
        end else begin
            if (w_issue_start) begin
                r_instr     <= r_table[w_grant_idx];
                r_winner    <= w_grant_idx;
                r_winner_oh <= w_grant_oh;
            end
            if (w_take_ack) begin
                r_instr      <= '0;
                r_last_grant <= r_winner;
            end
        end
    end

    assign o_interrupt_instruction = r_instr;
    assign o_irq_valid             = (r_state == ST_ISSUE);
    assign o_pending               = r_pending;
    assign o_dropped               = r_dropped;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed bench for interrupt_scheduler: hand-timed steps with immediate
// assertions against hand-computed expectations.
module tb_interrupt_scheduler;
    import interrupt_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  mask;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_instr;
    logic        ack;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  pending;
    logic [3:0]  dropped;

    int n_vec = 0;
    int n_err = 0;

    interrupt_scheduler #(.N_SRC(4), .INSTR_W(32)) dut (
        .i_clk                   (clk),
        .i_reset                 (rst),
        .i_req                   (req),
        .i_mask                  (mask),
        .i_cfg_we                (cfg_we),
        .i_cfg_idx               (cfg_idx),
        .i_cfg_instr             (cfg_instr),
        .i_irq_ack               (ack),
        .o_interrupt_instruction (instr),
        .o_irq_valid             (valid),
        .o_pending               (pending),
        .o_dropped               (dropped)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; mask = 4'hF; cfg_we = 1'b0;
        cfg_idx = '0; cfg_instr = '0; ack = 1'b0;
        step(); step();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_dropped", {28'd0, dropped}, 32'd0);
        rst = 1'b0;

        // Single request, latency and GAP
        cfg_we = 1'b1; cfg_idx = 2'(SRC_JUMP); cfg_instr = 32'hA000_0001; step(); cfg_we = 1'b0;
        req = 4'b0001; step();
        chk("t1_pend", {28'd0, pending}, 32'h1);
        chk("t1_not_yet", {31'd0, valid}, 32'd0);
        step();
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_instr", instr, 32'hA000_0001);
        step();
        chk("t1_hold", instr, 32'hA000_0001);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t1_gap_valid", {31'd0, valid}, 32'd0);
        chk("t1_gap_instr", instr, 32'd0);
        chk("t1_gap_pend", {28'd0, pending}, 32'd0);
        step();
        chk("t1_idle_valid", {31'd0, valid}, 32'd0);
        req = 4'b0000;

        // All four at once from reset: order 0,1,2,3
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_we = 1'b1; cfg_idx = 2'(k); cfg_instr = 32'hB000_0000 | 32'(k); step();
        end
        cfg_we = 1'b0;
        req = 4'hF; step();
        chk("t2_pend", {28'd0, pending}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_valid%0d", k), {31'd0, valid}, 32'd1);
            chk($sformatf("t2_instr%0d", k), instr, 32'hB000_0000 | 32'(k));
            ack = 1'b1; step(); ack = 1'b0;
            chk($sformatf("t2_gap%0d", k), instr, 32'd0);
            step();
            chk($sformatf("t2_idle%0d", k), {31'd0, valid}, 32'd0);
        end
        chk("t2_pend_done", {28'd0, pending}, 32'd0);
        req = 4'b0000; step();

        // Rotation: after grant to 1, edges on 0 and 2 -> 2 then 0
        req = 4'b0010; step(); step();
        chk("t3_g1", instr, 32'hB000_0001);
        req = 4'b0111; ack = 1'b1; step(); ack = 1'b0;
        chk("t3_pend", {28'd0, pending}, 32'h5);
        step(); step();
        chk("t3_g2", instr, 32'hB000_0002);
        ack = 1'b1; step(); ack = 1'b0; step(); step();
        chk("t3_g0", instr, 32'hB000_0000);
        ack = 1'b1; step(); ack = 1'b0; step();
        chk("t3_pend_done", {28'd0, pending}, 32'd0);
        req = 4'b0000; step();

        // Dropped edge, then edge coincident with ack re-arms
        req = 4'b0010; step();
        chk("t4_pend", {28'd0, pending}, 32'h2);
        req = 4'b0000; step();
        chk("t4_instr", instr, 32'hB000_0001);
        req = 4'b0010; step();
        chk("t4_dropped", {28'd0, dropped}, 32'h2);
        chk("t4_still_valid", {31'd0, valid}, 32'd1);
        req = 4'b0000; step();
        req = 4'b0010; ack = 1'b1; step(); ack = 1'b0;
        chk("t4_rearm_pend", {28'd0, pending}, 32'h2);
        chk("t4_rearm_drop", {28'd0, dropped}, 32'h2);
        chk("t4_gap", {31'd0, valid}, 32'd0);
        step(); step();
        chk("t4_second_valid", {31'd0, valid}, 32'd1);
        chk("t4_second_instr", instr, 32'hB000_0001);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t4_pend_done", {28'd0, pending}, 32'd0);
        step();
        req = 4'b0000; step();

        // Mask blocks issue; stray ack ignored; unmask issues next cycle
        mask = 4'b1110; req = 4'b0001; step();
        chk("t5_pend", {28'd0, pending}, 32'h1);
        ack = 1'b1; step();
        chk("t5_masked", {31'd0, valid}, 32'd0);
        chk("t5_ack_ignored", {28'd0, pending}, 32'h1);
        ack = 1'b0; step();
        chk("t5_masked2", {31'd0, valid}, 32'd0);
        mask = 4'hF; step();
        chk("t5_unmask_valid", {31'd0, valid}, 32'd1);
        chk("t5_unmask_instr", instr, 32'hB000_0000);
        ack = 1'b1; step(); ack = 1'b0; step();
        req = 4'b0000; step();

        // Table write during ISSUE, new value on next selection, async reset
        req = 4'b0100; step(); step();
        chk("t6_g2", instr, 32'hB000_0002);
        cfg_we = 1'b1; cfg_idx = 2'(SRC_COLLIDE); cfg_instr = 32'hC0DE_0002; step(); cfg_we = 1'b0;
        chk("t6_held", instr, 32'hB000_0002);
        chk("t6_held_valid", {31'd0, valid}, 32'd1);
        ack = 1'b1; step(); ack = 1'b0; step();
        req = 4'b0000; step();
        req = 4'b0100; step(); step();
        chk("t6_new_instr", instr, 32'hC0DE_0002);
        chk("t6_drop_kept", {28'd0, dropped}, 32'h2);
        req = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, valid}, 32'd0);
        chk("t6_async_instr", instr, 32'd0);
        step(); rst = 1'b0; step();
        chk("t6_pend_clr", {28'd0, pending}, 32'd0);
        chk("t6_drop_clr", {28'd0, dropped}, 32'd0);
        chk("t6_idle", {31'd0, valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
